bloom_rtt_filter: RTL and testbench

Hash-indexed SRAM table that consumes the tuple/hash requests issued by the TCP header-parsing stage. A data segment (`pkt_is_ack=0`) inserts a timestamped entry at both hash indices. An ACK queries both indices, and on a hit emits an RTT sample and clears the entries. It sits directly downstream of the parser and owns one SRAM port.

---
 rtl/bloom_rtt_filter_pkg.sv | 33 +++
 rtl/bloom_rtt_filter.sv | 205 ++++++++++++++++++++
 tb/tb_bloom_rtt_filter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bloom_rtt_filter_pkg.sv
// Shared definitions for the Bloom-style RTT filter: FSM state encoding,
// SRAM word field positions and the tuple signature fold.
package bloom_rtt_filter_pkg;

  localparam int VALID_BIT   = 35;
  localparam int SIG_HI      = 34;
  localparam int SIG_LO      = 32;
  localparam int TS_HI       = 31;
  localparam int SIG_WIDTH   = SIG_HI - SIG_LO + 1;
  localparam int TUPLE_WIDTH = 96;

  // One-hot state encoding, 9 states.
  typedef enum logic [8:0] {
    S_IDLE = 9'b0_0000_0001,
    S_INS0 = 9'b0_0000_0010,
    S_INS1 = 9'b0_0000_0100,
    S_RD0  = 9'b0_0000_1000,
    S_RD1  = 9'b0_0001_0000,
    S_WAIT = 9'b0_0010_0000,
    S_EVAL = 9'b0_0100_0000,
    S_CLR0 = 9'b0_1000_0000,
    S_CLR1 = 9'b1_0000_0000
  } state_e;

  // Fold the 96-bit tuple to 32 bits by XOR of its words, then fold the
  // low six bits of that down to a 3-bit signature.
  function automatic logic [SIG_WIDTH-1:0] sig_fold(input logic [TUPLE_WIDTH-1:0] tuple);
    logic [31:0] s;
    s = tuple[95:64] ^ tuple[63:32] ^ tuple[31:0];
    return s[2:0] ^ s[5:3];
  endfunction

endpackage

// File: rtl/bloom_rtt_filter.sv
// Hash-indexed SRAM filter that matches ACKs against earlier data segments.
// Inserts write a timestamped, signed entry at two hash indices; queries read
// both indices and, when both agree with the request, emit an RTT sample and
// clear the entries.
//
// state | meaning
// IDLE  | ready for a request
// INS0  | writing entry to index 0
// INS1  | writing entry to index 1
// RD0   | reading index 0
// RD1   | reading index 1 (first word may return here)
// WAIT  | waiting for outstanding read data
// EVAL  | one-cycle hit/miss decision, rtt_valid pulse on hit
// CLR0  | clearing index 0 after a hit
// CLR1  | clearing index 1 after a hit
module bloom_rtt_filter
  import bloom_rtt_filter_pkg::*;
#(
  parameter int HASH_BITS       = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int TS_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bloom_wr,
  output logic                       bloom_rdy,
  input  logic [HASH_BITS-1:0]       index_0,
  input  logic [HASH_BITS-1:0]       index_1,
  input  logic [TUPLE_WIDTH-1:0]     wire_tuple,
  input  logic                       pkt_is_ack,
  output logic [HASH_BITS-1:0]       sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  output logic                       sram_wr_req,
  output logic                       sram_rd_req,
  input  logic                       sram_req_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       rtt_valid,
  output logic [TS_WIDTH-1:0]        rtt_value,
  output logic [31:0]                num_inserts,
  output logic [31:0]                num_hits,
  output logic [31:0]                num_misses
);

  state_e                     state;
  logic [TS_WIDTH-1:0]        ts;
  logic [TS_WIDTH-1:0]        ts_req;
  logic [HASH_BITS-1:0]       idx0;
  logic [HASH_BITS-1:0]       idx1;
  logic [SIG_WIDTH-1:0]       sig;
  logic [SRAM_DATA_WIDTH-1:0] word0;
  logic [SRAM_DATA_WIDTH-1:0] word1;
  logic [1:0]                 fill;
  logic [SRAM_DATA_WIDTH-1:0] word0_n;
  logic [SRAM_DATA_WIDTH-1:0] word1_n;
  logic [1:0]                 fill_n;
  logic                       hit_n;

  // Free-running timestamp, one tick per clock.
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Read-return capture: slot 0 then slot 1, only while reads are outstanding.
  always_comb begin
    word0_n = word0;
    word1_n = word1;
    fill_n  = fill;
    if ((state == S_RD1 || state == S_WAIT) && sram_rd_vld) begin
      if (fill == 2'd0) begin
        word0_n = sram_rd_data;
        fill_n  = 2'd1;
      end else if (fill == 2'd1) begin
        word1_n = sram_rd_data;
        fill_n  = 2'd2;
      end
    end
  end

  // Hit decision on the words as they stand after this cycle's capture, so
  // rtt_valid can be registered on entry to EVAL.
  assign hit_n = word0_n[VALID_BIT] && word1_n[VALID_BIT] &&
                 (word0_n[SIG_HI:SIG_LO] == sig) &&
                 (word1_n[SIG_HI:SIG_LO] == sig) &&
                 (word0_n[TS_HI:0] == word1_n[TS_HI:0]);

  // Sequencing FSM with registered SRAM requests, status and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bloom_rdy    <= 1'b0;
      sram_addr    <= '0;
      sram_wr_data <= '0;
      sram_wr_req  <= 1'b0;
      sram_rd_req  <= 1'b0;
      rtt_valid    <= 1'b0;
      rtt_value    <= '0;
      num_inserts  <= '0;
      num_hits     <= '0;
      num_misses   <= '0;
      ts_req       <= '0;
      idx0         <= '0;
      idx1         <= '0;
      sig          <= '0;
      word0        <= '0;
      word1        <= '0;
      fill         <= '0;
    end else begin
      rtt_valid <= 1'b0;
      word0     <= word0_n;
      word1     <= word1_n;
      fill      <= fill_n;
      unique case (state)
        S_IDLE: begin
          bloom_rdy <= 1'b1;
          fill      <= '0;
          if (bloom_wr && bloom_rdy) begin
            bloom_rdy <= 1'b0;
            idx0      <= index_0;
            idx1      <= index_1;
            ts_req    <= ts;
            sig       <= sig_fold(wire_tuple);
            sram_addr <= index_0;
            if (pkt_is_ack) begin
              state       <= S_RD0;
              sram_rd_req <= 1'b1;
            end else begin
              state        <= S_INS0;
              sram_wr_req  <= 1'b1;
              sram_wr_data <= {1'b1, sig_fold(wire_tuple), ts};
            end
          end
        end
        S_INS0: begin
          if (sram_req_ack) begin
            state     <= S_INS1;
            sram_addr <= idx1;
          end
        end
        S_INS1: begin
          if (sram_req_ack) begin
            state       <= S_IDLE;
            sram_wr_req <= 1'b0;
            bloom_rdy   <= 1'b1;
            num_inserts <= num_inserts + 32'd1;
          end
        end
        S_RD0: begin
          if (sram_req_ack) begin
            state     <= S_RD1;
            sram_addr <= idx1;
          end
        end
        S_RD1: begin
          if (sram_req_ack) begin
            state       <= S_WAIT;
            sram_rd_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (fill_n == 2'd2) begin
            state     <= S_EVAL;
            rtt_valid <= hit_n;
            if (hit_n) rtt_value <= ts_req - word0_n[TS_HI:0];
          end
        end
        S_EVAL: begin
          // rtt_valid is high in EVAL exactly when the lookup hit.
          if (rtt_valid) begin
            state        <= S_CLR0;
            num_hits     <= num_hits + 32'd1;
            sram_addr    <= idx0;
            sram_wr_data <= '0;
            sram_wr_req  <= 1'b1;
          end else begin
            state      <= S_IDLE;
            num_misses <= num_misses + 32'd1;
            bloom_rdy  <= 1'b1;
          end
        end
        S_CLR0: begin
          if (sram_req_ack) begin
            state     <= S_CLR1;
            sram_addr <= idx1;
          end
        end
        S_CLR1: begin
          if (sram_req_ack) begin
            state       <= S_IDLE;
            sram_wr_req <= 1'b0;
            bloom_rdy   <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          sram_wr_req <= 1'b0;
          sram_rd_req <= 1'b0;
          bloom_rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_rtt_filter.sv
// Directed bench for bloom_rtt_filter with a behavioural SRAM responder
// (fixed read latency, controllable grant) and hand-computed expectations.
module tb_bloom_rtt_filter;

  localparam int HB  = 19;
  localparam int LAT = 2;

  // Signatures by hand: A -> s=0x29 -> 001^101 = 4 ; C -> s=0x7 -> 111^000 = 7
  localparam logic [95:0] TUPLE_A = 96'h00000001_00000000_00000028;
  localparam logic [95:0] TUPLE_B = 96'h12345678_9ABCDEF0_0F0F0F0F;
  localparam logic [95:0] TUPLE_C = 96'h00000007_00000000_00000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bloom_wr = 1'b0;
  logic          bloom_rdy;
  logic [HB-1:0] index_0 = '0;
  logic [HB-1:0] index_1 = '0;
  logic [95:0]   wire_tuple = '0;
  logic          pkt_is_ack = 1'b0;
  logic [HB-1:0] sram_addr;
  logic [35:0]   sram_wr_data;
  logic          sram_wr_req;
  logic          sram_rd_req;
  logic          sram_req_ack = 1'b0;
  logic [35:0]   sram_rd_data = '0;
  logic          sram_rd_vld = 1'b0;
  logic          rtt_valid;
  logic [31:0]   rtt_value;
  logic [31:0]   num_inserts;
  logic [31:0]   num_hits;
  logic [31:0]   num_misses;

  bloom_rtt_filter dut (
    .clk(clk), .reset(reset), .bloom_wr(bloom_wr), .bloom_rdy(bloom_rdy),
    .index_0(index_0), .index_1(index_1), .wire_tuple(wire_tuple),
    .pkt_is_ack(pkt_is_ack), .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_req(sram_wr_req), .sram_rd_req(sram_rd_req),
    .sram_req_ack(sram_req_ack), .sram_rd_data(sram_rd_data),
    .sram_rd_vld(sram_rd_vld), .rtt_valid(rtt_valid), .rtt_value(rtt_value),
    .num_inserts(num_inserts), .num_hits(num_hits), .num_misses(num_misses)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] tb_ts = '0;

  logic [35:0] mem [int];
  int          due_q[$];
  logic [35:0] dat_q[$];
  int          wr_cyc[$];
  int          wr_addr[$];
  logic [35:0] wr_dat[$];
  int          rtt_cnt = 0;
  logic [31:0] rtt_last = '0;
  int          rtt_cyc = -1;
  bit          ack_en = 1'b1;
  bit          both_req = 1'b0;
  int          inject_cnt = 0;
  logic [35:0] inject_word = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected timestamp: zero under reset, +1 every clock otherwise.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) tb_ts = '0;
    else       tb_ts = tb_ts + 32'd1;
  end

  // SRAM responder, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (sram_wr_req && sram_rd_req) both_req = 1'b1;
    sram_req_ack = ack_en && (sram_wr_req || sram_rd_req);
    if (sram_req_ack && sram_wr_req) begin
      mem[int'(sram_addr)] = sram_wr_data;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(sram_addr));
      wr_dat.push_back(sram_wr_data);
    end
    if (sram_req_ack && sram_rd_req) begin
      due_q.push_back(cyc + LAT);
      dat_q.push_back(mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 36'h0);
    end
    sram_rd_vld = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      sram_rd_vld  = 1'b1;
      sram_rd_data = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (inject_cnt > 0) begin
      sram_rd_vld  = 1'b1;
      sram_rd_data = inject_word;
      inject_cnt--;
    end
    if (rtt_valid) begin
      rtt_cnt++;
      rtt_last = rtt_value;
      rtt_cyc  = cyc;
    end
  end

  task automatic wait_ts(input logic [31:0] t);
    int n = 0;
    while (tb_ts != t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tb_ts != t) check_val("ts_timeout", tb_ts, t);
  endtask

  // Issue one request at a negedge; returns accept cycle and the cycle
  // in which bloom_rdy is next seen high.
  task automatic do_req(input logic [HB-1:0] i0, input logic [HB-1:0] i1,
                        input logic [95:0] t, input logic ack,
                        output int acc, output int rdy_cyc);
    int n = 0;
    while (!bloom_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    bloom_wr = 1'b1; index_0 = i0; index_1 = i1; wire_tuple = t; pkt_is_ack = ack;
    acc = cyc;
    @(negedge clk);
    bloom_wr = 1'b0;
    rdy_cyc = -1;
    n = 0;
    while (n < 200) begin
      if (bloom_rdy) begin
        rdy_cyc = cyc;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (rdy_cyc < 0) check_val("rdy_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_wr(input string tag, input int k, input int c, input int a, input logic [35:0] d);
    check_val({tag, "_cyc"}, wr_cyc[k], c);
    check_val({tag, "_addr"}, wr_addr[k], a);
    check_val({tag, "_data"}, wr_dat[k], d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, wb, rb;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_val("rst_rdy", bloom_rdy, 0);
    check_val("rst_req", {sram_wr_req, sram_rd_req}, 0);
    check_val("rst_rtt", rtt_valid, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("idle_rdy", bloom_rdy, 1);
    check_val("idle_req", {sram_wr_req, sram_rd_req}, 0);
    check_val("idle_cnt", {num_inserts, num_hits}, 0);
    check_val("idle_miss", num_misses, 0);

    // Insert A at ts=100
    wait_ts(32'd100);
    wb = wr_cyc.size();
    do_req(19'h00010, 19'h7FFFF, TUPLE_A, 1'b0, acc, rc);
    check_val("ins_nwr", wr_cyc.size() - wb, 2);
    check_wr("ins_w0", wb, acc + 1, 'h00010, 36'hC_0000_0064);
    check_wr("ins_w1", wb + 1, acc + 2, 'h7FFFF, 36'hC_0000_0064);
    check_val("ins_rdy_cyc", rc, acc + 3);
    check_val("ins_count", num_inserts, 1);

    // Query A 250 cycles later: hit
    wait_ts(32'd350);
    wb = wr_cyc.size(); rb = rtt_cnt;
    do_req(19'h00010, 19'h7FFFF, TUPLE_A, 1'b1, acc, rc);
    check_val("hit_npulse", rtt_cnt - rb, 1);
    check_val("hit_rtt", rtt_last, 32'd250);
    check_val("hit_rtt_cyc", rtt_cyc, acc + 3 + LAT);
    check_val("hit_nwr", wr_cyc.size() - wb, 2);
    check_wr("hit_clr0", wb, acc + 4 + LAT, 'h00010, 36'h0);
    check_wr("hit_clr1", wb + 1, acc + 5 + LAT, 'h7FFFF, 36'h0);
    check_val("hit_rdy_cyc", rc, acc + 6 + LAT);
    check_val("hit_count", num_hits, 1);

    // Query never-inserted tuple: miss on empty words
    wb = wr_cyc.size(); rb = rtt_cnt;
    do_req(19'h00123, 19'h00456, TUPLE_B, 1'b1, acc, rc);
    check_val("miss_npulse", rtt_cnt - rb, 0);
    check_val("miss_nwr", wr_cyc.size() - wb, 0);
    check_val("miss_rdy_cyc", rc, acc + 4 + LAT);
    check_val("miss_count", num_misses, 1);

    // Signature mismatch: A inserted, C queried at same indices
    do_req(19'h00040, 19'h00041, TUPLE_A, 1'b0, acc, rc);
    check_val("ins2_count", num_inserts, 2);
    wb = wr_cyc.size(); rb = rtt_cnt;
    do_req(19'h00040, 19'h00041, TUPLE_C, 1'b1, acc, rc);
    check_val("sig_npulse", rtt_cnt - rb, 0);
    check_val("sig_nwr", wr_cyc.size() - wb, 0);
    check_val("sig_miss_count", num_misses, 2);
    check_val("sig_hit_count", num_hits, 1);

    // Stalled grant in RD0, then reset mid-operation
    ack_en = 1'b0;
    wb = wr_cyc.size(); rb = rtt_cnt;
    bloom_wr = 1'b1; pkt_is_ack = 1'b1; index_0 = 19'h00500; index_1 = 19'h00501;
    wire_tuple = TUPLE_A;
    @(negedge clk);
    bloom_wr = 1'b0;
    repeat (5) @(negedge clk);
    check_val("stall_rd_req", sram_rd_req, 1);
    check_val("stall_addr", sram_addr, 19'h00500);
    check_val("stall_rdy", bloom_rdy, 0);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_req", {sram_wr_req, sram_rd_req}, 0);
    check_val("mid_rst_rdy", bloom_rdy, 0);
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    inject_word = 36'hC_0000_0064;
    inject_cnt = 2;
    repeat (8) @(negedge clk);
    check_val("late_vld_npulse", rtt_cnt - rb, 0);
    check_val("late_vld_nwr", wr_cyc.size() - wb, 0);
    check_val("post_rst_rdy", bloom_rdy, 1);
    check_val("post_rst_req", {sram_wr_req, sram_rd_req}, 0);
    check_val("post_rst_cnt", {num_inserts, num_hits}, 0);
    check_val("post_rst_miss", num_misses, 0);

    // Timestamp wrap with index_0 == index_1 (entry stamped 0xFFFFFFF0)
    mem[32'h300] = 36'hF_FFFF_FFF0;
    wait_ts(32'h10);
    wb = wr_cyc.size(); rb = rtt_cnt;
    do_req(19'h00300, 19'h00300, TUPLE_C, 1'b1, acc, rc);
    check_val("wrap_npulse", rtt_cnt - rb, 1);
    check_val("wrap_rtt", rtt_last, 32'h20);
    check_val("wrap_nwr", wr_cyc.size() - wb, 2);
    check_wr("wrap_clr0", wb, acc + 4 + LAT, 'h00300, 36'h0);
    check_wr("wrap_clr1", wb + 1, acc + 5 + LAT, 'h00300, 36'h0);
    check_val("wrap_hits", num_hits, 1);
    check_val("wrap_mem", mem[32'h300], 36'h0);

    check_val("one_req_line", both_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
